bht_update_ctrl: RTL
====================

BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, sets update-queue entries; power of two, 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ex_valid  input  1  EX stage holds a resolved branch this cycle.
REQ-005 ex_pc, ex_dest  input  32 each  branch PC and resolved target.
REQ-006 ex_taken  input  1  actual branch outcome.
REQ-007 ex_pred, ex_pred_dest  input  1 / 32  prediction carried from IF.
REQ-008 ex_ready  output  1  queue can accept; equals not-full.
REQ-009 bht_ready  input  1  BHT write port free this cycle.
REQ-010 bht_op  output  1  one-cycle BHT write strobe.
REQ-011 bht_pc, bht_dest  output  32 each  BHT write address and target.
REQ-012 bht_success  output  1  outcome written to BHT.
REQ-013 flush  output  1  one-cycle pipeline flush pulse.
REQ-014 redirect_pc  output  32  fetch target, valid while flush=1.
REQ-015 busy  output  1  queue non-empty or FSM not IDLE.

Function
REQ-016 Accept: ex_valid and ex_ready push {pc,dest,taken} at the tail; ex_valid with ex_ready=0 is dropped and not flagged.
REQ-017 Mispredict: accepted branch with ex_taken!=ex_pred, or ex_taken=1 and ex_pred=1 with ex_dest!=ex_pred_dest.
REQ-018 Mispredict response: flush=1 and redirect_pc driven on the next cycle (registered, latency 1); redirect_pc=ex_dest if taken, else ex_pc+4 (32-bit wrap).
REQ-019 FSM states IDLE, ISSUE, FLUSH; IDLE->ISSUE when queue non-empty; ISSUE->IDLE when last entry issued; any state->FLUSH on mispredict accept; FLUSH->ISSUE if non-empty else IDLE after exactly one cycle.
REQ-020 Issue: in ISSUE with bht_ready=1, head is popped and presented with bht_op=1 in the same cycle (combinational from head); at most one issue per cycle.
REQ-021 Issue is suppressed in FLUSH; queued entries are retained (resolved branches still train the BHT).
REQ-022 Simultaneous push and pop when full: push is refused (ex_ready reflects full state at cycle start).
REQ-023 Simultaneous push and pop when empty: entry enters queue; issue follows no earlier than the next cycle (no bypass).
REQ-024 Ordering: BHT writes occur in strict acceptance order.
REQ-025 Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-026 Back-to-back mispredicts produce back-to-back flush pulses, each with its own redirect_pc.

Reset
REQ-027 On rst: queue emptied, FSM=IDLE, bht_op=0, flush=0, redirect_pc=0, busy=0, ex_ready=1.
REQ-028 rst mid-operation discards queued entries and any pending flush; no write strobe during or in the cycle after rst release.

Configuration
REQ-029 Macro BHT_UPDATE_STATS_EN: when defined, adds outputs stat_branches and stat_mispred (32-bit, saturating, cleared by rst) counting accepted branches and mispredicts; when undefined, the ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-030 Shared package holds the FSM state enum, the queue-entry struct {pc,dest,taken}, and constant PC_STEP=4.
REQ-031 One sub-module, upd_fifo (parameterised DEPTH, push/pop/full/empty); FSM and mispredict logic live in the top.

Verification
REQ-032 Single correct prediction pc=0x100, taken, pred=1, dest match -> no flush; bht_op with pc=0x100, success=1 one cycle later.
REQ-033 Not-taken mispredict pc=0x200, pred=1 -> flush=1, redirect_pc=0x204 next cycle; BHT write success=0 follows.
REQ-034 Target mismatch pc=0x300, dest=0x400, pred_dest=0x500 -> redirect_pc=0x400.
REQ-035 bht_ready=0 for 10 cycles with 5 pushes, DEPTH=4 -> ex_ready=0 after 4, 5th dropped; release -> 4 writes in order.
REQ-036 rst asserted with 3 queued entries -> busy=0, no bht_op after release.
REQ-037 pc=0xFFFFFFFC not taken, mispredicted -> redirect_pc=0x00000000.

Source files
------------

// File: rtl/bht_update_ctrl_pkg.sv
// bht_update_ctrl_pkg: shared types and constants for the BHT update controller.
package bht_update_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dest;
        logic        taken;
    } entry_t;
    localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/bht_update_ctrl_if.sv
// bht_update_ctrl_if: EX-stage resolve, BHT write and flush signals of the update controller.
interface bht_update_ctrl_if;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_dest;
    logic        ex_taken;
    logic        ex_pred;
    logic [31:0] ex_pred_dest;
    logic        ex_ready;
    logic        bht_ready;
    logic        bht_op;
    logic [31:0] bht_pc;
    logic [31:0] bht_dest;
    logic        bht_success;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        busy;
    modport slave (
        input  ex_valid, ex_pc, ex_dest, ex_taken, ex_pred, ex_pred_dest, bht_ready,
        output ex_ready, bht_op, bht_pc, bht_dest, bht_success, flush, redirect_pc, busy
    );
    modport master (
        output ex_valid, ex_pc, ex_dest, ex_taken, ex_pred, ex_pred_dest, bht_ready,
        input  ex_ready, bht_op, bht_pc, bht_dest, bht_success, flush, redirect_pc, busy
    );
endinterface

// File: rtl/bht_update_ctrl_fifo.sv
// upd_fifo: DEPTH-entry FIFO of resolved branches; head is read combinationally.
module upd_fifo
    import bht_update_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   din,
    input  logic                     pop,
    output entry_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    entry_t          mem [DEPTH];
    logic [AW-1:0]   wp, rp;
    logic            do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl: queues resolved branches for BHT training and flags mispredicts.
// Optional BHT_UPDATE_STATS_EN adds saturating branch/mispredict counters.
module bht_update_ctrl
    import bht_update_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    bht_update_ctrl_if.slave    bus
`ifdef BHT_UPDATE_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispred
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t          state, state_nxt;
    entry_t          head, din;
    logic            full, empty, accept, mispred, pop;
    logic [CW-1:0]   count, cnt_nxt;
    logic            flush_q;
    logic [31:0]     redirect_q;
    assign accept  = bus.ex_valid && !full;
    assign mispred = accept && ((bus.ex_taken != bus.ex_pred) ||
                     (bus.ex_taken && bus.ex_pred && bus.ex_dest != bus.ex_pred_dest));
    assign pop     = state == ISSUE && bus.bht_ready && !empty;
    assign cnt_nxt = count + CW'(accept) - CW'(pop);
    assign din     = '{pc: bus.ex_pc, dest: bus.ex_dest, taken: bus.ex_taken};
    upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    // Every state leaves after one cycle on the same rule: a mispredict wins, otherwise issue while anything remains.
    always_comb begin
        state_nxt = state;
        state_nxt = mispred ? FLUSH : (cnt_nxt != '0 ? ISSUE : IDLE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            state   <= state_nxt;
            flush_q <= mispred;
            if (mispred) redirect_q <= bus.ex_taken ? bus.ex_dest : bus.ex_pc + PC_STEP;
        end
    end
    assign bus.ex_ready    = !full;
    assign bus.bht_op      = pop;
    assign bus.bht_pc      = head.pc;
    assign bus.bht_dest    = head.dest;
    assign bus.bht_success = head.taken;
    assign bus.flush       = flush_q;
    assign bus.redirect_pc = redirect_q;
    assign bus.busy        = !empty || state != IDLE;
`ifdef BHT_UPDATE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (accept && !(&stat_branches)) stat_branches <= stat_branches + 1'b1;
            if (mispred && !(&stat_mispred)) stat_mispred <= stat_mispred + 1'b1;
        end
    end
`endif
endmodule
